// File: rtl/mem_march_bist_if.sv
// Memory-side port of the March C- BIST engine: address, write strobe/data out,
// registered read data back from the memory tile.
interface mem_march_bist_if #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 8
);
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_wr_en;
    logic [DATA_BITS-1:0] mem_wdata;
    logic [DATA_BITS-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wr_en,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_march_bist.sv
// March C- self-test engine for a byte-wide registered-read memory tile.
// Define MEM_BIST_STOP_ON_FAIL_EN to end the test on the first detected mismatch.
//
// state   | meaning
// IDLE    | waiting for start after reset
// M0      | up:   w d0
// M1      | up:   r d0, w d1
// M2      | up:   r d1, w d0
// M3      | down: r d0, w d1
// M4      | down: r d1, w d0
// M5      | up:   r d0
// DRAIN   | final compare of the last M5 read
// DONE    | result held, waiting for start
module mem_march_bist #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 8,
    parameter logic [DATA_BITS-1:0] BG = {DATA_BITS{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [ADDR_BITS-1:0] fail_addr,
    output logic [2:0]           fail_elem,
    mem_march_bist_if.master     mem
);

    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
    } state_t;

    localparam logic [ADDR_BITS-1:0] ADDR_LAST = {ADDR_BITS{1'b1}};
    localparam logic [DATA_BITS-1:0] D0 = BG;
    localparam logic [DATA_BITS-1:0] D1 = ~BG;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 wr_en_q, wr_en_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 fail_q, fail_d;
    logic [ADDR_BITS-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]           fail_elem_q, fail_elem_d;
    logic                 chk_valid_q, chk_valid_d;
    logic [DATA_BITS-1:0] chk_exp_q, chk_exp_d;
    logic [ADDR_BITS-1:0] chk_addr_q, chk_addr_d;
    logic [2:0]           chk_elem_q, chk_elem_d;
    logic                 mismatch;

    assign mismatch = chk_valid_q && (mem.mem_rdata != chk_exp_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        chk_valid_d = 1'b0;
        chk_exp_d   = '0;
        chk_addr_d  = addr_q;
        chk_elem_d  = 3'd0;
        wr_en_d     = 1'b0;
        wdata_d     = '0;

        // Read data for this cycle's address returns next cycle; latch what to expect.
        case (state_q)
            S_M1: begin chk_valid_d = 1'b1; chk_exp_d = D0; chk_elem_d = 3'd1; end
            S_M2: begin chk_valid_d = 1'b1; chk_exp_d = D1; chk_elem_d = 3'd2; end
            S_M3: begin chk_valid_d = 1'b1; chk_exp_d = D0; chk_elem_d = 3'd3; end
            S_M4: begin chk_valid_d = 1'b1; chk_exp_d = D1; chk_elem_d = 3'd4; end
            S_M5: begin chk_valid_d = 1'b1; chk_exp_d = D0; chk_elem_d = 3'd5; end
            default: ;
        endcase

        if (mismatch && !fail_q) begin
            fail_d      = 1'b1;
            fail_addr_d = chk_addr_q;
            fail_elem_d = chk_elem_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_M0;
                    addr_d      = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = 3'd0;
                end
            end
            S_M0: begin
                if (addr_q == ADDR_LAST) begin state_d = S_M1; addr_d = '0; end
                else addr_d = addr_q + 1'b1;
            end
            S_M1: begin
                if (addr_q == ADDR_LAST) begin state_d = S_M2; addr_d = '0; end
                else addr_d = addr_q + 1'b1;
            end
            S_M2: begin
                if (addr_q == ADDR_LAST) begin state_d = S_M3; addr_d = ADDR_LAST; end
                else addr_d = addr_q + 1'b1;
            end
            S_M3: begin
                if (addr_q == '0) begin state_d = S_M4; addr_d = ADDR_LAST; end
                else addr_d = addr_q - 1'b1;
            end
            S_M4: begin
                if (addr_q == '0) begin state_d = S_M5; addr_d = '0; end
                else addr_d = addr_q - 1'b1;
            end
            S_M5: begin
                if (addr_q == ADDR_LAST) begin state_d = S_DRAIN; addr_d = '0; end
                else addr_d = addr_q + 1'b1;
            end
            S_DRAIN: begin
                state_d = S_DONE;
                addr_d  = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef MEM_BIST_STOP_ON_FAIL_EN
        if (mismatch) begin
            state_d     = S_DONE;
            addr_d      = '0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            chk_valid_d = 1'b0;
        end
`endif

        // Memory strobes are registered, so decode them from the upcoming state.
        case (state_d)
            S_M0, S_M2, S_M4: begin wr_en_d = 1'b1; wdata_d = D0; end
            S_M1, S_M3:       begin wr_en_d = 1'b1; wdata_d = D1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
            chk_valid_q <= 1'b0;
            chk_exp_q   <= '0;
            chk_addr_q  <= '0;
            chk_elem_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            chk_valid_q <= chk_valid_d;
            chk_exp_q   <= chk_exp_d;
            chk_addr_q  <= chk_addr_d;
            chk_elem_q  <= chk_elem_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign fail          = fail_q;
    assign fail_addr     = fail_addr_q;
    assign fail_elem     = fail_elem_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wr_en = wr_en_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_march_bist.sv
// Bench for mem_march_bist: two engines (BG=0 with injectable faults, BG=A5 fault-free)
// against faulty/clean memory models, checked by a scoreboard fed from an algorithmic March C- model.
module tb_mem_march_bist;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int N  = 1 << AW;
`ifdef MEM_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic mem_init = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]         busy, done, fail, mwe;
    logic [1:0][AW-1:0] faddr, maddr;
    logic [1:0][2:0]    felem;
    logic [1:0][DW-1:0] mwd;

    mem_march_bist_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) mif0 ();
    mem_march_bist_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) mif1 ();

    mem_march_bist #(.ADDR_BITS(AW), .DATA_BITS(DW), .BG(8'h00)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[0]), .done(done[0]),
        .fail(fail[0]), .fail_addr(faddr[0]), .fail_elem(felem[0]), .mem(mif0));
    mem_march_bist #(.ADDR_BITS(AW), .DATA_BITS(DW), .BG(8'hA5)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[1]), .done(done[1]),
        .fail(fail[1]), .fail_addr(faddr[1]), .fail_elem(felem[1]), .mem(mif1));

    assign maddr[0] = mif0.mem_addr;  assign maddr[1] = mif1.mem_addr;
    assign mwe[0]   = mif0.mem_wr_en; assign mwe[1]   = mif1.mem_wr_en;
    assign mwd[0]   = mif0.mem_wdata; assign mwd[1]   = mif1.mem_wdata;

    // fault configuration for memory 0 (written only by the stimulus process)
    bit          sa_en = 1'b0;
    logic [AW-1:0] sa_addr = '0;
    logic [DW-1:0] sa_and = '1, sa_or = '0;
    bit          cf_en = 1'b0;
    logic [AW-1:0] cf_aggr = '0, cf_vict = '0;
    logic [2:0]  cf_abit = '0, cf_vbit = '0;

    function automatic logic [DW-1:0] sa_apply(input logic [AW-1:0] a, input logic [DW-1:0] v);
        return (sa_en && a == sa_addr) ? ((v & sa_and) | sa_or) : v;
    endfunction

    logic [DW-1:0] m0 [N];
    logic [DW-1:0] m1 [N];

    // Registered-read memories; a write cycle returns the old word.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < N; i++) begin
                m0[i] <= '0;
                m1[i] <= '0;
            end
        end else begin
            mif0.mem_rdata <= sa_apply(mif0.mem_addr, m0[mif0.mem_addr]);
            mif1.mem_rdata <= m1[mif1.mem_addr];
            if (mif0.mem_wr_en) begin
                m0[mif0.mem_addr] <= mif0.mem_wdata;
                if (cf_en && mif0.mem_addr == cf_aggr && m0[cf_aggr][cf_abit] && !mif0.mem_wdata[cf_abit])
                    m0[cf_vict] <= m0[cf_vict] ^ (DW'(1) << cf_vbit);
            end
            if (mif1.mem_wr_en) m1[mif1.mem_addr] <= mif1.mem_wdata;
        end
    end

    typedef struct {
        logic          f;
        logic [AW-1:0] a;
        logic [2:0]    e;
        int            done_cyc;
        int            busy_n;
        int            wr_n;
    } res_t;
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    res_t exp_res [2][$];
    wr_t  exp_wr  [2][$];
    wr_t  mq [$];

    // March C- run on a plain array: 6 elements, each a loop over all addresses.
    task automatic model(input logic [DW-1:0] bg, input bit faults, output res_t r);
        logic [DW-1:0] m [N];
        logic [AW-1:0] a;
        logic [DW-1:0] rv, ev, wv;
        bit found;
        int gf;
        found = 1'b0; gf = 0;
        r.f = 1'b0; r.a = '0; r.e = '0; r.wr_n = 0;
        mq.delete();
        for (int i = 0; i < N; i++) m[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int p = 0; p < N; p++) begin
                a = (e == 3 || e == 4) ? AW'(N - 1 - p) : AW'(p);
                if (e > 0) begin
                    rv = faults ? sa_apply(a, m[a]) : m[a];
                    ev = (e == 2 || e == 4) ? ~bg : bg;
                    if (!found && rv != ev) begin
                        found = 1'b1; gf = e * N + p;
                        r.f = 1'b1; r.a = a; r.e = 3'(e);
                    end
                end
                if (e < 5) begin
                    wv = (e == 1 || e == 3) ? ~bg : bg;
                    if (faults && cf_en && a == cf_aggr && m[a][cf_abit] && !wv[cf_abit])
                        m[cf_vict] = m[cf_vict] ^ (DW'(1) << cf_vbit);
                    m[a] = wv;
                    if (!(STOP && found && (e * N + p) > gf + 1)) begin
                        mq.push_back('{a, wv});
                        r.wr_n++;
                    end
                end
            end
        end
        r.done_cyc = (STOP && found) ? gf + 3 : 6 * N + 2;
        r.busy_n   = r.done_cyc - 1;
    endtask

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    endtask

    // Monitor/scoreboard: the only process that compares.
    bit mon_rst_prev = 1'b1;
    bit done_prev [2];
    int bcnt [2];
    int wcnt [2];

    initial begin
        wr_t  w;
        res_t r;
        forever begin
            @(negedge clk);
            if (!mon_rst_prev) begin
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("reset_outputs%0d", k),
                        {busy[k], done[k], fail[k], faddr[k], felem[k], maddr[k], mwe[k], mwd[k]}, 32'd0);
                    exp_res[k].delete();
                    exp_wr[k].delete();
                    bcnt[k] = 0; wcnt[k] = 0; done_prev[k] = 1'b0;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (mwe[k]) begin
                        wcnt[k]++;
                        if (exp_wr[k].size() == 0) chk($sformatf("wr_unexpected%0d", k), mwe[k], 0);
                        else begin
                            w = exp_wr[k].pop_front();
                            chk($sformatf("wr_addr%0d", k), maddr[k], w.a);
                            chk($sformatf("wr_data%0d", k), mwd[k], w.d);
                        end
                    end
                    if (busy[k]) bcnt[k]++;
                    if (done[k] && !done_prev[k]) begin
                        if (exp_res[k].size() == 0) chk($sformatf("done_unexpected%0d", k), done[k], 0);
                        else begin
                            r = exp_res[k].pop_front();
                            chk($sformatf("done_cycle%0d", k), cyc, r.done_cyc);
                            chk($sformatf("fail%0d", k), fail[k], r.f);
                            chk($sformatf("fail_addr%0d", k), faddr[k], r.a);
                            chk($sformatf("fail_elem%0d", k), felem[k], r.e);
                            chk($sformatf("busy_cycles%0d", k), bcnt[k], r.busy_n);
                            chk($sformatf("write_count%0d", k), wcnt[k], r.wr_n);
                            chk($sformatf("wr_en_at_done%0d", k), mwe[k], 0);
                        end
                        bcnt[k] = 0; wcnt[k] = 0;
                    end else if (!busy[k] && !done[k]) begin
                        bcnt[k] = 0; wcnt[k] = 0;
                    end
                    if (exp_res[k].size() > 0 && cyc > exp_res[k][0].done_cyc + 20) begin
                        r = exp_res[k].pop_front();
                        chk($sformatf("done_timeout%0d", k), cyc, r.done_cyc);
                    end
                    done_prev[k] = done[k];
                end
            end
            mon_rst_prev = rst_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input int t0);
        res_t r;
        model(8'h00, 1'b1, r);
        foreach (mq[i]) exp_wr[0].push_back(mq[i]);
        r.done_cyc += t0;
        exp_res[0].push_back(r);
        model(8'hA5, 1'b0, r);
        foreach (mq[i]) exp_wr[1].push_back(mq[i]);
        r.done_cyc += t0;
        exp_res[1].push_back(r);
    endtask

    task automatic init_mem();
        tick(); mem_init = 1'b1;
        tick(); mem_init = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 800; i++) begin
            if (exp_res[0].size() == 0 && exp_res[1].size() == 0) break;
            tick();
        end
    endtask

    task automatic run_one();
        int t0;
        init_mem();
        t0 = cyc;
        push_expect(t0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
    endtask

    task automatic clear_faults();
        sa_en = 1'b0; cf_en = 1'b0; sa_and = '1; sa_or = '0;
    endtask

    initial begin
        int t0;
        int bitn;
        rst_n = 1'b0;
        mem_init = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        mem_init = 1'b0;
        tick();

        // fault-free
        clear_faults();
        run_one();

        // bit 0 stuck-at-0 at address 5
        sa_en = 1'b1; sa_addr = 5'd5; sa_and = 8'hFE; sa_or = 8'h00;
        run_one();
        clear_faults();

        // falling bit 0 of address 10 flips bit 7 of address 9
        cf_en = 1'b1; cf_aggr = 5'd10; cf_vict = 5'd9; cf_abit = 3'd0; cf_vbit = 3'd7;
        run_one();
        clear_faults();

        // reset in the middle of M3, then a clean run
        init_mem();
        t0 = cyc;
        push_expect(t0);
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < t0 + 1 + 3 * N + 7) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        run_one();

        // start held high across a whole run and into DONE: back-to-back runs
        init_mem();
        t0 = cyc;
        push_expect(t0);
        push_expect(t0 + 6 * N + 2);
        start = 1'b1;
        while (cyc < t0 + 6 * N + 8) tick();
        start = 1'b0;
        wait_idle();

        // randomized stuck-at and coupling faults
        for (int it = 0; it < 8; it++) begin
            clear_faults();
            if ($urandom_range(0, 1) == 0) begin
                bitn = $urandom_range(0, DW - 1);
                sa_en = 1'b1;
                sa_addr = AW'($urandom_range(0, N - 1));
                sa_and = ~(DW'(1) << bitn);
                sa_or = ($urandom_range(0, 1) == 1) ? (DW'(1) << bitn) : '0;
            end else begin
                cf_en = 1'b1;
                cf_aggr = AW'($urandom_range(0, N - 1));
                cf_vict = cf_aggr + AW'($urandom_range(1, N - 1));
                cf_abit = 3'($urandom_range(0, DW - 1));
                cf_vbit = 3'($urandom_range(0, DW - 1));
            end
            run_one();
        end
        clear_faults();

        wait_idle();
        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
